// File: rtl/alu_seq_driver.sv
// Command front-end for the 4-bit combinational ALU: queues commands, drives the
// ALU pins for one cycle, captures result/flags and returns them over valid/ready.
module alu_seq_driver #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_s,
  output logic       rsp_c,
  output logic       rsp_zero,
  output logic       rsp_ovf,
  output logic       rsp_err,
  output logic [2:0] alu_select,
  output logic       alu_in_c,
  output logic [3:0] alu_in_x,
  output logic [3:0] alu_in_y,
  input  logic [3:0] alu_out_s,
  input  logic       alu_out_c,
  input  logic       alu_zero,
  input  logic       alu_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [10:0] mem_q [DEPTH];
  logic [10:0] mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]  state_q, state_d;
  logic [2:0]  alu_select_q, alu_select_d;
  logic        alu_in_c_q, alu_in_c_d;
  logic [3:0]  alu_in_x_q, alu_in_x_d;
  logic [3:0]  alu_in_y_q, alu_in_y_d;
  logic [3:0]  rsp_s_q, rsp_s_d;
  logic        rsp_c_q, rsp_c_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_err_q, rsp_err_d;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [10:0] head;
  logic        head_legal;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign head_legal = (head[10:8] <= 3'd4);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {cmd_op, cmd_x, cmd_y};
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    alu_select_d = alu_select_q;
    alu_in_c_d   = alu_in_c_q;
    alu_in_x_d   = alu_in_x_q;
    alu_in_y_d   = alu_in_y_q;
    rsp_s_d      = rsp_s_q;
    rsp_c_d      = rsp_c_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pop = !empty;
      end
      ST_ISSUE: begin
        // The ALU leaves flags undefined for logic ops, so derive them here.
        rsp_s_d   = alu_out_s;
        rsp_err_d = 1'b0;
        if (alu_select_q == 3'd0 || alu_select_q == 3'd1) begin
          rsp_c_d    = alu_out_c;
          rsp_ovf_d  = alu_overflow;
          rsp_zero_d = alu_zero;
        end else begin
          rsp_c_d    = 1'b0;
          rsp_ovf_d  = 1'b0;
          rsp_zero_d = (alu_out_s == 4'd0);
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (empty) state_d = ST_IDLE;
          else       pop     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (head_legal) begin
        alu_select_d = head[10:8];
        alu_in_x_d   = head[7:4];
        alu_in_y_d   = head[3:0];
        alu_in_c_d   = (head[10:8] == 3'd1);
        state_d      = ST_ISSUE;
      end else begin
        rsp_s_d    = 4'd0;
        rsp_c_d    = 1'b0;
        rsp_zero_d = 1'b0;
        rsp_ovf_d  = 1'b0;
        rsp_err_d  = 1'b1;
        state_d    = ST_RESP;
      end
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_IDLE;
      alu_select_q <= '0;
      alu_in_c_q   <= 1'b0;
      alu_in_x_q   <= '0;
      alu_in_y_q   <= '0;
      rsp_s_q      <= '0;
      rsp_c_q      <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      alu_select_q <= alu_select_d;
      alu_in_c_q   <= alu_in_c_d;
      alu_in_x_q   <= alu_in_x_d;
      alu_in_y_q   <= alu_in_y_d;
      rsp_s_q      <= rsp_s_d;
      rsp_c_q      <= rsp_c_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_s      = rsp_s_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign alu_select = alu_select_q;
  assign alu_in_c   = alu_in_c_q;
  assign alu_in_x   = alu_in_x_q;
  assign alu_in_y   = alu_in_y_q;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Bench for alu_seq_driver: behavioural ALU on the pins, a table of directed
// vectors, multi-cycle corner sequences and a randomized scoreboard run.
module tb_alu_seq_driver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_x = '0;
  logic [3:0] cmd_y = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_s;
  logic       rsp_c, rsp_zero, rsp_ovf, rsp_err;
  logic [2:0] alu_select;
  logic       alu_in_c;
  logic [3:0] alu_in_x, alu_in_y;
  logic [3:0] alu_out_s;
  logic       alu_out_c, alu_zero, alu_overflow;

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       zero;
    logic       ovf;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
    rsp_t       exp;
    int         lat;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  vec_t vecs[10];

  alu_seq_driver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_select(alu_select), .alu_in_c(alu_in_c),
    .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
    .alu_out_s(alu_out_s), .alu_out_c(alu_out_c),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU; logic ops drive deliberately misleading flags.
  logic [3:0] alu_yy;
  logic [4:0] alu_sum;
  always_comb begin
    alu_yy       = alu_in_c ? ~alu_in_y : alu_in_y;
    alu_sum      = {1'b0, alu_in_x} + {1'b0, alu_yy} + {4'b0000, alu_in_c};
    alu_out_s    = 4'hA;
    alu_out_c    = 1'b1;
    alu_overflow = 1'b1;
    alu_zero     = 1'b1;
    case (alu_select)
      3'd0, 3'd1: begin
        alu_out_s    = alu_sum[3:0];
        alu_out_c    = alu_sum[4];
        alu_overflow = (alu_in_x[3] == alu_yy[3]) && (alu_sum[3] != alu_in_x[3]);
        alu_zero     = (alu_sum[3:0] == 4'd0);
      end
      3'd2: begin alu_out_s = ~alu_in_x;            alu_zero = (alu_out_s != 4'd0); end
      3'd3: begin alu_out_s = alu_in_x & alu_in_y;  alu_zero = (alu_out_s != 4'd0); end
      3'd4: begin alu_out_s = alu_in_x | alu_in_y;  alu_zero = (alu_out_s != 4'd0); end
      default: ;
    endcase
  end

  // Reference model: plain integer arithmetic on the command fields.
  function automatic rsp_t model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    rsp_t m;
    int xs, ys, r;
    m  = '0;
    xs = (x > 7) ? int'(x) - 16 : int'(x);
    ys = (y > 7) ? int'(y) - 16 : int'(y);
    case (op)
      3'd0: begin
        r = int'(x) + int'(y);
        m.s = r[3:0]; m.c = (r > 15); m.ovf = ((xs + ys) > 7) || ((xs + ys) < -8);
      end
      3'd1: begin
        r = int'(x) - int'(y) + 16;
        m.s = r[3:0]; m.c = (x >= y); m.ovf = ((xs - ys) > 7) || ((xs - ys) < -8);
      end
      3'd2: m.s = ~x;
      3'd3: m.s = x & y;
      3'd4: m.s = x | y;
      default: begin m.err = 1'b1; return m; end
    endcase
    m.zero = (m.s == 4'd0);
    return m;
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                              input logic [3:0] s, input logic c, input logic z,
                              input logic o, input logic e, input int lat);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.lat = lat;
    v.exp.s = s; v.exp.c = c; v.exp.zero = z; v.exp.ovf = o; v.exp.err = e;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepted commands, check responses in order at handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_rsp: got response s=0x%0h err=%0b, expected none", rsp_s, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("scoreboard_rsp", int'({rsp_s, rsp_c, rsp_zero, rsp_ovf, rsp_err}), int'(mon_e));
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_x, cmd_y));
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                               output int acc_cyc, output bit ok);
    ok = 1'b0;
    acc_cyc = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rsp"}, int'({rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_ovf, rsp_err}), 0);
    checkOutput({tag, "_alu"}, int'({alu_select, alu_in_c, alu_in_x, alu_in_y}), 0);
    checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  task automatic runVector(input vec_t v);
    int acc, lat;
    bit ok, seen;
    applyStimulus(v.op, v.x, v.y, acc, ok);
    if (!ok) return;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if ((cyc - acc) == 1 && v.op <= 3'd4)
        checkOutput("alu_pins", int'({alu_select, alu_in_c, alu_in_x, alu_in_y}),
                    int'({v.op, (v.op == 3'd1), v.x, v.y}));
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = cyc - acc;
        checkOutput("latency", lat, v.lat);
        checkOutput("vec_rsp", int'({rsp_s, rsp_c, rsp_zero, rsp_ovf, rsp_err}), int'(v.exp));
      end
    end
    if (!seen) checkOutput("rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic waitDrain(input string nm);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    checkOutput(nm, exp_q.size(), 0);
  endtask

  initial begin
    int acc, start, held, bx;
    bit ok, got;

    vecs[0] = mk(3'd0, 4'h3, 4'h5, 4'h8, 0, 0, 1, 0, 2);
    vecs[1] = mk(3'd1, 4'h5, 4'h5, 4'h0, 1, 1, 0, 0, 2);
    vecs[2] = mk(3'd1, 4'h2, 4'h3, 4'hF, 0, 0, 0, 0, 2);
    vecs[3] = mk(3'd3, 4'hC, 4'hA, 4'h8, 0, 0, 0, 0, 2);
    vecs[4] = mk(3'd3, 4'h5, 4'hA, 4'h0, 0, 1, 0, 0, 2);
    vecs[5] = mk(3'd2, 4'hF, 4'h0, 4'h0, 0, 1, 0, 0, 2);
    vecs[6] = mk(3'd4, 4'h1, 4'h2, 4'h3, 0, 0, 0, 0, 2);
    vecs[7] = mk(3'd6, 4'h7, 4'h9, 4'h0, 0, 0, 0, 1, 1);
    vecs[8] = mk(3'd0, 4'h1, 4'h1, 4'h2, 0, 0, 0, 0, 2);
    vecs[9] = mk(3'd0, 4'h7, 4'h9, 4'h0, 1, 1, 0, 0, 2);

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkResetState("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) runVector(vecs[i]);

    $display("[TB] illegal followed by add, back to back");
    start = rsp_seen;
    applyStimulus(3'd6, 4'h3, 4'h4, acc, ok);
    applyStimulus(3'd0, 4'h1, 4'h1, acc, ok);
    waitDrain("illegal_pair_drain");
    @(negedge clk);
    checkOutput("illegal_pair_count", rsp_seen - start, 2);

    $display("[TB] backpressure");
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_op = 3'($urandom_range(0, 4)); cmd_x = 4'($urandom); cmd_y = 4'($urandom);
    for (int t = 0; t < 2 * DEPTH + 8; t++) begin
      @(negedge clk);
      got = cmd_ready;
      if (got) acc++;
      @(posedge clk); #1;
      if (got) begin
        cmd_op = 3'($urandom_range(0, 4)); cmd_x = 4'($urandom); cmd_y = 4'($urandom);
      end
    end
    cmd_valid = 1'b0;
    checkOutput("bp_accepts", acc, DEPTH + 1);
    @(negedge clk);
    checkOutput("bp_cmd_ready", int'(cmd_ready), 0);
    checkOutput("bp_rsp_valid", int'(rsp_valid), 1);
    held = int'({rsp_s, rsp_c, rsp_zero, rsp_ovf, rsp_err});
    repeat (3) @(negedge clk);
    checkOutput("bp_hold", int'({rsp_s, rsp_c, rsp_zero, rsp_ovf, rsp_err}), held);
    start = rsp_seen;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    waitDrain("bp_drain");
    @(negedge clk);
    checkOutput("bp_drain_count", rsp_seen - start, DEPTH + 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_x     = 4'($urandom);
      cmd_y     = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    waitDrain("random_drain");

    $display("[TB] reset while issuing");
    repeat (3) @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(3'd0, 4'h2, 4'h2, acc, ok);
    bx = int'($urandom_range(1, 15));
    applyStimulus(3'd4, 4'(bx), 4'h0, acc, ok);
    applyStimulus(3'd0, 4'h4, 4'h4, acc, ok);
    applyStimulus(3'd3, 4'hF, 4'hF, acc, ok);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("midop_issue_x", int'({rsp_valid, alu_select, alu_in_x}), int'({1'b0, 3'd4, 4'(bx)}));
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midop_reset");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    checkOutput("post_reset_quiet", int'(got), 0);
    runVector(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
